alien_fleet_ctrl: RTL and testbench

//  Formation controller for the alien grid. Owns one shared fleet origin (fleet_x, fleet_y),
//  the march direction and the per-alien alive mask. Steps the formation on frame_clk ticks,

---
 rtl/alien_fleet_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alien_fleet_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_fleet_ctrl.sv
// Alien formation controller: shared grid origin, march direction, alive mask,
// edge-triggered reversal/drop and kill handling.
module alien_fleet_ctrl #(
  parameter int unsigned COLS      = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned PITCH     = 16,
  parameter int unsigned X_START   = 100,
  parameter int unsigned Y_START   = 40,
  parameter int unsigned X_MIN     = 10,
  parameter int unsigned X_MAX     = 629,
  parameter int unsigned Y_MAX     = 349,
  parameter int unsigned X_STEP    = 4,
  parameter int unsigned Y_STEP    = 8,
  parameter int unsigned FRAME_DIV = 2,
  localparam int unsigned IW       = $clog2(COLS * ROWS)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   start,
  input  logic                   kill_valid,
  input  logic [IW-1:0]          kill_idx,
  output logic [9:0]             fleet_x,
  output logic [9:0]             fleet_y,
  output logic                   dir,
  output logic [COLS*ROWS-1:0]   alive,
  output logic                   step_pulse,
  output logic                   kill_hit,
  output logic                   landed,
  output logic                   cleared
);

  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StMarch, StDrop, StLanded, StCleared} state_e;

  state_e          state_q, state_d;
  logic [9:0]      fleet_x_q, fleet_x_d;
  logic [9:0]      fleet_y_q, fleet_y_d;
  logic            dir_q, dir_d;
  logic [N-1:0]    alive_q, alive_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            frame_q;
  logic            step_pulse_q, step_pulse_d;
  logic            kill_hit_q, kill_hit_d;

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  logic [CW-1:0]   lcol, rcol;
  logic [RW-1:0]   brow;
  logic [10:0]     left_edge, right_edge, drop_y, new_bottom;
  logic            hit_right, hit_left;
  logic            tick, div_last;
  logic [31:0]     kill_idx_ext;
  logic            kill_ok;

  // Occupied extent of the grid, derived from the registered mask.
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (alive_q[r*COLS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
    lcol = '0;
    rcol = '0;
    brow = '0;
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (col_any[c]) lcol = CW'(c);
    end
    for (int c = 0; c < int'(COLS); c++) begin
      if (col_any[c]) rcol = CW'(c);
    end
    for (int r = 0; r < int'(ROWS); r++) begin
      if (row_any[r]) brow = RW'(r);
    end
  end

  always_comb begin
    left_edge  = 11'(fleet_x_q) + 11'(lcol) * 11'(PITCH);
    right_edge = 11'(fleet_x_q) + (11'(rcol) + 11'd1) * 11'(PITCH) - 11'd1;
    drop_y     = 11'(fleet_y_q) + 11'(Y_STEP);
    new_bottom = drop_y + (11'(brow) + 11'd1) * 11'(PITCH) - 11'd1;
    hit_right  = (right_edge + 11'(X_STEP)) > 11'(X_MAX);
    hit_left   = left_edge < 11'(X_MIN + X_STEP);
  end

  assign tick         = frame_clk & ~frame_q;
  assign div_last     = (div_cnt_q == DW'(FRAME_DIV - 1));
  assign kill_idx_ext = 32'(kill_idx);
  assign kill_ok      = kill_valid && (kill_idx_ext < N);

  always_comb begin
    state_d      = state_q;
    fleet_x_d    = fleet_x_q;
    fleet_y_d    = fleet_y_q;
    dir_d        = dir_q;
    alive_d      = alive_q;
    div_cnt_d    = div_cnt_q;
    step_pulse_d = 1'b0;
    kill_hit_d   = 1'b0;

    unique case (state_q)
      StIdle, StLanded, StCleared: begin
        if (start) begin
          fleet_x_d = 10'(X_START);
          fleet_y_d = 10'(Y_START);
          dir_d     = 1'b1;
          alive_d   = '1;
          div_cnt_d = '0;
          state_d   = StMarch;
        end
      end
      StMarch, StDrop: begin
        if (alive_q == '0) begin
          state_d = StCleared;
        end else if (tick) begin
          if (div_last) begin
            div_cnt_d    = '0;
            step_pulse_d = 1'b1;
            if (state_q == StMarch) begin
              // Reaching an edge costs one step with no horizontal move.
              if (dir_q) begin
                if (hit_right) state_d = StDrop;
                else           fleet_x_d = fleet_x_q + 10'(X_STEP);
              end else begin
                if (hit_left) state_d = StDrop;
                else          fleet_x_d = fleet_x_q - 10'(X_STEP);
              end
            end else begin
              fleet_y_d = drop_y[9:0];
              dir_d     = ~dir_q;
              state_d   = (new_bottom >= 11'(Y_MAX)) ? StLanded : StMarch;
            end
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Kill lands on top of any reload; the hit report reflects the pre-edge mask.
    if (kill_ok) begin
      kill_hit_d        = alive_q[kill_idx];
      alive_d[kill_idx] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      fleet_x_q    <= 10'(X_START);
      fleet_y_q    <= 10'(Y_START);
      dir_q        <= 1'b1;
      alive_q      <= '1;
      div_cnt_q    <= '0;
      frame_q      <= 1'b0;
      step_pulse_q <= 1'b0;
      kill_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fleet_x_q    <= fleet_x_d;
      fleet_y_q    <= fleet_y_d;
      dir_q        <= dir_d;
      alive_q      <= alive_d;
      div_cnt_q    <= div_cnt_d;
      frame_q      <= frame_clk;
      step_pulse_q <= step_pulse_d;
      kill_hit_q   <= kill_hit_d;
    end
  end

  assign fleet_x    = fleet_x_q;
  assign fleet_y    = fleet_y_q;
  assign dir        = dir_q;
  assign alive      = alive_q;
  assign step_pulse = step_pulse_q;
  assign kill_hit   = kill_hit_q;
  assign landed     = (state_q == StLanded);
  assign cleared    = (state_q == StCleared);

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Bench for alien_fleet_ctrl: random frame/kill stimulus against a step-level
// behavioural model of the formation, plus directed spot checks.
module tb_alien_fleet_ctrl;

  localparam int COLS = 8, ROWS = 4, PITCH = 16;
  localparam int X_START = 100, Y_START = 40, X_MIN = 10, X_MAX = 629, Y_MAX = 349;
  localparam int X_STEP = 4, Y_STEP = 8, FRAME_DIV = 2;
  localparam int N = COLS * ROWS;
  localparam int MIdle = 0, MMarch = 1, MDrop = 2, MLanded = 3, MCleared = 4;

  logic        Clk = 1'b0;
  logic        Reset_n, frame_clk, start, kill_valid;
  logic [4:0]  kill_idx;
  logic [9:0]  fleet_x, fleet_y;
  logic        dir, step_pulse, kill_hit, landed, cleared;
  logic [31:0] alive;

  always #5 Clk = ~Clk;

  alien_fleet_ctrl #(.FRAME_DIV(FRAME_DIV)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .start      (start),
    .kill_valid (kill_valid),
    .kill_idx   (kill_idx),
    .fleet_x    (fleet_x),
    .fleet_y    (fleet_y),
    .dir        (dir),
    .alive      (alive),
    .step_pulse (step_pulse),
    .kill_hit   (kill_hit),
    .landed     (landed),
    .cleared    (cleared)
  );

  int total = 0, bad = 0;
  string phase = "reset";

  // Model state
  int          m_x, m_y, m_mode, m_ticks, m_steps = 0;
  bit          m_dir, m_prev, m_sp, m_kh;
  logic [31:0] m_alive;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s.%s got=%0d exp=%0d", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = X_START; m_y = Y_START; m_dir = 1; m_alive = '1;
    m_mode = MIdle; m_ticks = 0; m_prev = 0; m_sp = 0; m_kh = 0;
  endtask

  task automatic model_edge(input logic fr, input logic st, input logic kv,
                            input logic [4:0] ki);
    bit tick;
    logic [31:0] pre;
    int lcol, rcol, brow;
    tick = fr && !m_prev;
    m_prev = fr;
    pre = m_alive;
    m_sp = 0;
    m_kh = 0;
    if (m_mode == MIdle || m_mode == MLanded || m_mode == MCleared) begin
      if (st) begin
        m_x = X_START; m_y = Y_START; m_dir = 1; m_alive = '1; m_ticks = 0;
        m_mode = MMarch;
      end
    end else if (pre == 0) begin
      m_mode = MCleared;
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == FRAME_DIV) begin
        m_ticks = 0;
        m_steps++;
        m_sp = 1;
        lcol = COLS; rcol = -1; brow = -1;
        for (int i = 0; i < N; i++) begin
          if (pre[i]) begin
            if (i % COLS < lcol) lcol = i % COLS;
            if (i % COLS > rcol) rcol = i % COLS;
            if (i / COLS > brow) brow = i / COLS;
          end
        end
        if (m_mode == MMarch) begin
          if (m_dir) begin
            if (m_x + (rcol + 1) * PITCH - 1 + X_STEP > X_MAX) m_mode = MDrop;
            else m_x += X_STEP;
          end else begin
            if (m_x + lcol * PITCH < X_MIN + X_STEP) m_mode = MDrop;
            else m_x -= X_STEP;
          end
        end else begin
          m_y += Y_STEP;
          m_dir = !m_dir;
          m_mode = (m_y + (brow + 1) * PITCH - 1 >= Y_MAX) ? MLanded : MMarch;
        end
      end
    end
    if (kv && ki < N) begin
      m_kh = pre[ki];
      m_alive[ki] = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("fleet_x", 32'(fleet_x), 32'(m_x));
    chk("fleet_y", 32'(fleet_y), 32'(m_y));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("alive", alive, m_alive);
    chk("step_pulse", 32'(step_pulse), 32'(m_sp));
    chk("kill_hit", 32'(kill_hit), 32'(m_kh));
    chk("landed", 32'(landed), 32'(m_mode == MLanded));
    chk("cleared", 32'(cleared), 32'(m_mode == MCleared));
  endtask

  task automatic cyc(input logic fr, input logic st, input logic kv, input logic [4:0] ki);
    frame_clk = fr; start = st; kill_valid = kv; kill_idx = ki;
    @(posedge Clk);
    model_edge(fr, st, kv, ki);
    #1;
    check_all();
  endtask

  task automatic rand_cyc(input int kill_pm, input int start_pm);
    logic fr, st, kv;
    fr = ($urandom_range(0, 3) != 0) ? ~frame_clk : frame_clk;
    st = ($urandom_range(0, 999) < start_pm);
    kv = !st && ($urandom_range(0, 999) < kill_pm);
    cyc(fr, st, kv, 5'($urandom_range(0, N - 1)));
  endtask

  task automatic run_steps(input int n, input int kill_pm);
    int target, guard;
    target = m_steps + n;
    guard = 0;
    while (m_steps < target && guard < 40 * n * FRAME_DIV + 100) begin
      rand_cyc(kill_pm, 0);
      guard++;
    end
    chk("step_budget", 32'(m_steps), 32'(target));
  endtask

  task automatic async_reset();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_x", 32'(fleet_x), 32'(X_START));
    chk("rst_y", 32'(fleet_y), 32'(Y_START));
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_alive", alive, 32'hFFFF_FFFF);
    chk("rst_flags", {28'd0, step_pulse, kill_hit, landed, cleared}, 32'd0);
    model_reset();
    frame_clk = 0; start = 0; kill_valid = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    int order[N];
    int guard, tmp, j;
    Reset_n = 0; frame_clk = 0; start = 0; kill_valid = 0; kill_idx = '0;
    #12;
    model_reset();
    check_all();
    chk("rst_x_const", 32'(fleet_x), 32'd100);
    chk("rst_alive_const", alive, 32'hFFFF_FFFF);
    @(negedge Clk);
    Reset_n = 1;

    // Idle ignores ticks until start
    phase = "idle";
    for (int i = 0; i < 10; i++) rand_cyc(0, 0);
    chk("idle_x", 32'(fleet_x), 32'd100);

    phase = "t1";
    cyc(0, 1, 0, 0);
    run_steps(100, 0);
    chk("x500", 32'(fleet_x), 32'd500);
    run_steps(1, 0);
    chk("edge_nomove_x", 32'(fleet_x), 32'd500);
    chk("edge_nomove_y", 32'(fleet_y), 32'd40);
    run_steps(1, 0);
    chk("drop_y", 32'(fleet_y), 32'd48);
    chk("drop_dir", 32'(dir), 32'd0);

    phase = "t3";
    run_steps(122, 0);
    chk("x12", 32'(fleet_x), 32'd12);
    run_steps(1, 0);
    chk("left_nomove_x", 32'(fleet_x), 32'd12);
    run_steps(1, 0);
    chk("drop2_y", 32'(fleet_y), 32'd56);
    chk("drop2_dir", 32'(dir), 32'd1);

    phase = "t4";
    guard = 0;
    while (m_mode != MLanded && guard < 60000) begin
      rand_cyc(0, 0);
      guard++;
    end
    chk("landed", 32'(landed), 32'd1);
    chk("landed_y", 32'(fleet_y), 32'd288);
    for (int i = 0; i < 40; i++) rand_cyc(0, 0);
    chk("frozen_y", 32'(fleet_y), 32'd288);
    chk("frozen_landed", 32'(landed), 32'd1);

    phase = "t5";
    cyc(0, 1, 0, 0);
    chk("restart_alive", alive, 32'hFFFF_FFFF);
    for (int i = 0; i < N; i++) order[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < N; i++) begin
      cyc(($urandom_range(0, 1) == 1), 0, 1, 5'(order[i]));
      chk("kill_hit_live", 32'(kill_hit), 32'd1);
    end
    chk("all_dead", alive, 32'd0);
    cyc(0, 0, 0, 0);
    chk("cleared", 32'(cleared), 32'd1);
    cyc(0, 0, 1, 5'd3);
    chk("rekill", 32'(kill_hit), 32'd0);
    cyc(0, 1, 0, 0);
    chk("restart2_alive", alive, 32'hFFFF_FFFF);
    chk("restart2_x", 32'(fleet_x), 32'd100);
    chk("restart2_cleared", 32'(cleared), 32'd0);

    phase = "t2";
    for (int r = 0; r < ROWS; r++) begin
      cyc(0, 0, 1, 5'(r * COLS + 7));
      chk("col7_hit", 32'(kill_hit), 32'd1);
    end
    run_steps(104, 0);
    chk("x516", 32'(fleet_x), 32'd516);
    run_steps(1, 0);
    chk("edge516_x", 32'(fleet_x), 32'd516);
    run_steps(1, 0);
    chk("drop516_y", 32'(fleet_y), 32'd48);

    phase = "t6";
    async_reset();
    cyc(0, 1, 0, 0);
    run_steps(100, 0);
    chk("t6_x500", 32'(fleet_x), 32'd500);
    cyc(0, 0, 0, 0);
    guard = 0;
    while (m_ticks != FRAME_DIV - 1 && guard < 10) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      guard++;
    end
    cyc(1, 0, 1, 5'd7);
    chk("coinc_step", 32'(step_pulse), 32'd1);
    chk("coinc_kill", 32'(kill_hit), 32'd1);
    chk("coinc_alive7", 32'(alive[7]), 32'd0);
    chk("coinc_x", 32'(fleet_x), 32'd500);
    cyc(0, 0, 0, 0);
    async_reset();
    for (int i = 0; i < 12; i++) rand_cyc(0, 0);
    chk("post_rst_idle_x", 32'(fleet_x), 32'd100);
    chk("post_rst_idle_y", 32'(fleet_y), 32'd40);

    phase = "t7";
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 1500; i++) rand_cyc(120, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
